// File: rtl/avalon_mem_pkg.sv
// Shared widths and types for the Avalon-MM word-memory responder.
package avalon_mem_pkg;
    localparam int AVM_DATA_W           = 64;
    localparam int AVM_ADDR_W           = 32;
    localparam int AVM_BE_W             = 8;
    localparam int DEFAULT_READ_LATENCY = 2;

    typedef struct packed {
        logic                  valid;
        logic [AVM_DATA_W-1:0] data;
    } pipe_entry_t;
endpackage

// File: rtl/read_latency_pipe.sv
// Fixed-latency return path: READ_LATENCY shift stages plus the registered read-data output.
import avalon_mem_pkg::*;

module read_latency_pipe #(
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  pipe_entry_t           in_entry,
    output logic [AVM_DATA_W-1:0] rd_data,
    output logic                  rd_valid
);
    pipe_entry_t stage [READ_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage[i] <= '0;
            end
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            stage[0] <= in_entry;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
            rd_valid <= stage[READ_LATENCY-1].valid;
            // Read data holds its last returned value between valid pulses.
            if (stage[READ_LATENCY-1].valid) begin
                rd_data <= stage[READ_LATENCY-1].data;
            end
        end
    end
endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave with a byte-writable word memory, pipelined reads and an outstanding-read limit.
import avalon_mem_pkg::*;

module avalon_mem_responder #(
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int MAX_PENDING  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AVM_ADDR_W-1:0] avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [AVM_DATA_W-1:0] avs_writedata,
    input  logic [AVM_BE_W-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [AVM_DATA_W-1:0] avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [15:0]           rd_count,
    output logic                  protocol_err
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [AVM_DATA_W-1:0] mem [DEPTH];
    logic [3:0]            outstanding;
    logic [IDX_W-1:0]      idx;
    logic                  addr_oob;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  err_set;
    pipe_entry_t           rd_entry;

    // A return this cycle frees its slot, so a full counter only stalls when nothing is returning.
    assign avs_waitrequest = (outstanding == 4'(MAX_PENDING)) && !avs_readdatavalid;

    assign addr_oob  = avs_address >= AVM_ADDR_W'(DEPTH);
    assign idx       = avs_address[IDX_W-1:0];
    assign rd_accept = avs_read && !avs_waitrequest;
    assign wr_accept = avs_write && !avs_read && !avs_waitrequest && !addr_oob;
    assign err_set   = !avs_waitrequest &&
                       (((avs_read || avs_write) && addr_oob) || (avs_read && avs_write));

    always_comb begin
        rd_entry       = '0;
        rd_entry.valid = rd_accept;
        if (rd_accept && !addr_oob) begin
            rd_entry.data = mem[idx];
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int b = 0; b < AVM_BE_W; b++) begin
                if (avs_byteenable[b]) begin
                    mem[idx][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding  <= '0;
            rd_count     <= '0;
            protocol_err <= 1'b0;
        end else begin
            case ({rd_accept, avs_readdatavalid})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
            if (avs_readdatavalid) begin
                rd_count <= rd_count + 16'd1;
            end
            if (err_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

    read_latency_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_entry (rd_entry),
        .rd_data  (avs_readdata),
        .rd_valid (avs_readdatavalid)
    );
endmodule
